// File: rtl/button_press_decoder.sv
// rtl/button_press_decoder.sv - debounced button level to short/long/repeat event pulses
module button_press_decoder #(
   parameter int LONG_PRESS_CYCLES = 100_000_000,
   parameter int REPEAT_CYCLES     = 20_000_000,
   parameter bit REPEAT_EN         = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic short_press,
   output logic long_press,
   output logic repeat_tick,
   output logic held
);

   // One counter serves both the long-press qualification and the repeat interval,
   // so it is sized for the larger of the two; it is always cleared before it could wrap.
   localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES
                                                                   : REPEAT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             btn_q;
   logic             rise;

   // A press only starts on a low-to-high transition; btn_q resets high so a button
   // already held when reset releases must be let go before it can register.
   assign rise = btn_in & ~btn_q;

   // Press classification FSM; the reset input is active-high despite its name.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         btn_q       <= 1'b1;
         short_press <= 1'b0;
         long_press  <= 1'b0;
         repeat_tick <= 1'b0;
         held        <= 1'b0;
      end else begin
         btn_q       <= btn_in;
         short_press <= 1'b0;
         long_press  <= 1'b0;
         repeat_tick <= 1'b0;

         case (state)
            IDLE: begin
               if (rise) begin
                  // The rising sample itself is the first high sample of the press.
                  state <= PRESSED;
                  cnt   <= CNT_ONE;
                  held  <= 1'b1;
               end else begin
                  held  <= 1'b0;
               end
            end

            PRESSED: begin
               if (!btn_in) begin
                  // Any single low sample ends the press; the debouncer upstream
                  // already did the filtering.
                  short_press <= 1'b1;
                  state       <= IDLE;
                  cnt         <= '0;
                  held        <= 1'b0;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= LONG;
                  cnt        <= '0;
                  held       <= 1'b1;
               end else begin
                  cnt  <= cnt + CNT_ONE;
                  held <= 1'b1;
               end
            end

            LONG: begin
               if (!btn_in) begin
                  // The long press was already reported; release is silent.
                  state <= IDLE;
                  cnt   <= '0;
                  held  <= 1'b0;
               end else if (REPEAT_EN && (cnt == REPEAT_LAST)) begin
                  repeat_tick <= 1'b1;
                  cnt         <= '0;
                  held        <= 1'b1;
               end else begin
                  held <= 1'b1;
                  if (REPEAT_EN) begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_press_decoder.sv
// tb/tb_button_press_decoder.sv - self-checking bench for button_press_decoder
module tb_button_press_decoder;

   localparam int L = 8;
   localparam int R = 4;

   logic clk;
   logic rst_n;
   logic btn_in;
   logic sa, la, ra, ha;
   logic sb, lb, rb, hb;

   int errors = 0;
   int checks = 0;

   // Event counters per DUT (0 = repeat enabled, 1 = repeat disabled)
   int n_short [2];
   int n_long  [2];
   int n_rep   [2];
   int n_held  [2];

   // Reference model state: length of the current high run of a valid press
   int m_run  [2];
   bit m_prev [2];

   typedef struct {
      bit         rst;
      bit         btn;
      logic [3:0] exp;   // {short, long, repeat, held}
   } vec_t;

   vec_t tbl[$];

   button_press_decoder #(
      .LONG_PRESS_CYCLES(L),
      .REPEAT_CYCLES    (R),
      .REPEAT_EN        (1'b1)
   ) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in),
      .short_press(sa),
      .long_press (la),
      .repeat_tick(ra),
      .held       (ha)
   );

   button_press_decoder #(
      .LONG_PRESS_CYCLES(L),
      .REPEAT_CYCLES    (R),
      .REPEAT_EN        (1'b0)
   ) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in),
      .short_press(sb),
      .long_press (lb),
      .repeat_tick(rb),
      .held       (hb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: expected outputs depend only on the length of the
   // current run of high samples that started from a genuine low-to-high edge.
   task automatic model_step(input int k, input bit rst, input bit btn, output logic [3:0] e);
      e = 4'b0000;
      if (rst) begin
         m_run[k]  = 0;
         m_prev[k] = 1'b1;
      end else begin
         if (btn) begin
            if (m_run[k] > 0) m_run[k] = m_run[k] + 1;
            else if (!m_prev[k]) m_run[k] = 1;
            e[0] = (m_run[k] > 0);
            e[2] = (m_run[k] == L);
            e[1] = (k == 0) && (m_run[k] > L) && (((m_run[k] - L) % R) == 0);
         end else begin
            e[3]     = (m_run[k] > 0) && (m_run[k] < L);
            m_run[k] = 0;
         end
         m_prev[k] = btn;
      end
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 2; k++) begin
         n_short[k] = 0;
         n_long[k]  = 0;
         n_rep[k]   = 0;
         n_held[k]  = 0;
      end
   endtask

   // Apply one sample, then compare both DUTs against the model 1 time unit after the edge.
   task automatic step(input bit r, input bit b);
      logic [3:0] e0, e1;
      logic [3:0] a0, a1;
      rst_n  = r;
      btn_in = b;
      @(posedge clk);
      model_step(0, r, b, e0);
      model_step(1, r, b, e1);
      #1;
      a0 = {sa, la, ra, ha};
      a1 = {sb, lb, rb, hb};
      check("a_short", a0[3], e0[3]);
      check("a_long",  a0[2], e0[2]);
      check("a_rep",   a0[1], e0[1]);
      check("a_held",  a0[0], e0[0]);
      check("b_short", a1[3], e1[3]);
      check("b_long",  a1[2], e1[2]);
      check("b_rep",   a1[1], e1[1]);
      check("b_held",  a1[0], e1[0]);
      check("a_onehot", int'(a0[3]) + int'(a0[2]) + int'(a0[1]) <= 1, 1);
      n_short[0] += int'(a0[3]); n_long[0] += int'(a0[2]); n_rep[0] += int'(a0[1]); n_held[0] += int'(a0[0]);
      n_short[1] += int'(a1[3]); n_long[1] += int'(a1[2]); n_rep[1] += int'(a1[1]); n_held[1] += int'(a1[0]);
   endtask

   task automatic add_vec(input bit r, input bit b, input logic [3:0] e);
      vec_t v;
      v.rst = r;
      v.btn = b;
      v.exp = e;
      tbl.push_back(v);
   endtask

   initial begin
      rst_n  = 1'b1;
      btn_in = 1'b0;
      clear_counts();

      // Hand-derived table: two short presses (1,1,1,0,1,1,1,0) then exactly L highs
      add_vec(1, 0, 4'b0000);
      add_vec(0, 0, 4'b0000);
      add_vec(0, 1, 4'b0001);
      add_vec(0, 1, 4'b0001);
      add_vec(0, 1, 4'b0001);
      add_vec(0, 0, 4'b1000);
      add_vec(0, 1, 4'b0001);
      add_vec(0, 1, 4'b0001);
      add_vec(0, 1, 4'b0001);
      add_vec(0, 0, 4'b1000);
      add_vec(0, 0, 4'b0000);
      for (int i = 1; i <= L; i++) add_vec(0, 1, (i == L) ? 4'b0101 : 4'b0001);
      add_vec(0, 0, 4'b0000);
      add_vec(0, 0, 4'b0000);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].btn);
         check("tbl_a", int'({sa, la, ra, ha}), int'(tbl[i].exp));
         check("tbl_b", int'({sb, lb, rb, hb}), int'(tbl[i].exp));
      end

      // Seven highs: one short press, held for seven cycles
      clear_counts();
      step(0, 0);
      for (int i = 0; i < L - 1; i++) step(0, 1);
      step(0, 0);
      step(0, 0);
      check("t2_short", n_short[0], 1);
      check("t2_long",  n_long[0],  0);
      check("t2_held",  n_held[0],  L - 1);

      // Twenty highs: one long press, three repeats; none when repeat disabled
      clear_counts();
      for (int i = 0; i < 20; i++) step(0, 1);
      step(0, 0);
      step(0, 0);
      check("t4_long_a",  n_long[0],  1);
      check("t4_rep_a",   n_rep[0],   3);
      check("t4_short_a", n_short[0], 0);
      check("t6_long_b",  n_long[1],  1);
      check("t6_rep_b",   n_rep[1],   0);

      // Reset in the middle of a held press: silent until a fresh low-high edge
      for (int i = 0; i < 4; i++) step(0, 1);
      clear_counts();
      step(1, 1);
      step(1, 1);
      for (int i = 0; i < 10; i++) step(0, 1);
      check("t5_pulses", n_short[0] + n_long[0] + n_rep[0], 0);
      check("t5_held",   n_held[0], 0);
      step(0, 0);
      for (int i = 0; i < 3; i++) step(0, 1);
      step(0, 0);
      check("t5_short", n_short[0], 1);

      // Randomised runs of highs and lows with occasional resets
      for (int n = 0; n < 300; n++) begin
         bit          lvl;
         int unsigned len;
         lvl = $urandom_range(0, 1) != 0;
         len = $urandom_range(1, 26);
         for (int j = 0; j < int'(len); j++) begin
            step(($urandom_range(0, 99) == 0), lvl);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
